tri_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one tri-state data bus between N requesters. It owns the `enb` inputs of the per-requester `triStateBuff` instances (W-bit, active-high enable) and guarantees that at most one driver is enabled at any time. It inserts a one-cycle all-off turnaround between owners so two drivers never overlap. It sits beside the shared bus, one level above the buffers, and is clocked with the rest of the datapath.

---
 rtl/tri_bus_arbiter_if.sv | 27 ++
 rtl/tri_bus_arbiter.sv | 117 +++++++++++
 tb/tb_tri_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tri_bus_arbiter_if.sv
// Shared tri-state bus control bundle: per-requester requests in, one-hot buffer enables out.
// master = arbiter side, slave = requester side.
interface tri_bus_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [2:0]   ownerId;
  logic         busBusy;
  logic         turnaround;

  modport master (
    input  req,
    output grant,
    output ownerId,
    output busBusy,
    output turnaround
  );

  modport slave (
    output req,
    input  grant,
    input  ownerId,
    input  busBusy,
    input  turnaround
  );
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus: one-hot grant with one dead cycle between owners.
// Optional ARB_TIMEOUT_EN preempts an owner after MAX_HOLD cycles while others are waiting.
module tri_bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  tri_bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

  state_e       state_q;
  logic [N-1:0] grant_q;
  logic [2:0]   owner_q;
  logic [2:0]   rr_ptr_q;
  logic         busy_q;
  logic         turn_q;

  logic [N-1:0] req_v;
  logic [N-1:0] mask_hi;
  logic [N-1:0] req_hi;
  logic [N-1:0] pick_src;
  logic [N-1:0] pick_oh;
  logic [N-1:0] enc0, enc1, enc2;
  logic [2:0]   winner_d;
  logic         found_d;
  logic         owner_req_d;
  logic         preempt_d;

  assign req_v = bus.req;

  // Requesters above the last owner get first pick; otherwise wrap to the lowest index.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_req
      assign mask_hi[gi] = (3'(gi) > rr_ptr_q);
      assign enc0[gi]    = pick_oh[gi] && ((gi % 2) == 1);
      assign enc1[gi]    = pick_oh[gi] && (((gi / 2) % 2) == 1);
      assign enc2[gi]    = pick_oh[gi] && (gi >= 4);
    end
  endgenerate

  assign req_hi   = req_v & mask_hi;
  assign pick_src = (|req_hi) ? req_hi : req_v;
  assign pick_oh  = pick_src & (~pick_src + {{(N-1){1'b0}}, 1'b1});
  assign found_d  = |pick_src;
  assign winner_d = {|enc2, |enc1, |enc0};

  assign owner_req_d = |(req_v & grant_q);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q;
  logic       others_d;

  assign others_d  = |(req_v & ~grant_q);
  assign preempt_d = (hold_q == 8'(MAX_HOLD - 1)) && others_d;
`else
  logic unused_max_hold;

  assign unused_max_hold = (MAX_HOLD > 0);
  assign preempt_d       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= 3'd0;
      busy_q   <= 1'b0;
      turn_q   <= 1'b0;
      rr_ptr_q <= 3'(N - 1);
`ifdef ARB_TIMEOUT_EN
      hold_q   <= 8'd0;
`endif
    end else begin
      unique case (state_q)
        GRANT: begin
          if (!owner_req_d || preempt_d) begin
            state_q <= TURN;
            grant_q <= '0;
            busy_q  <= 1'b0;
            turn_q  <= 1'b1;
          end
`ifdef ARB_TIMEOUT_EN
          // Saturate so a late competitor still triggers preemption immediately.
          else if (hold_q != 8'(MAX_HOLD - 1)) begin
            hold_q <= hold_q + 8'd1;
          end
`endif
        end
        IDLE, TURN: begin
          turn_q <= 1'b0;
          if (found_d) begin
            state_q  <= GRANT;
            grant_q  <= pick_oh;
            owner_q  <= winner_d;
            rr_ptr_q <= winner_d;
            busy_q   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_q   <= 8'd0;
`endif
          end else begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.ownerId    = owner_q;
  assign bus.busBusy    = busy_q;
  assign bus.turnaround = turn_q;
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: directed scenarios plus randomized traffic against a round-robin model.
// Honours ARB_TIMEOUT_EN the same way as the design.
module tb_tri_bus_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  tri_bus_arbiter_if #(.N(N)) bus ();

  tri_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state: who owns the bus (-1 = nobody), last owner, cycles held, dead-cycle flag.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_hold  = 0;
  int m_id    = 0;
  bit m_turn  = 1'b0;

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_grant();
    return (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic rs);
    int w;
    if (rs) begin
      m_owner = -1; m_turn = 1'b0; m_last = N - 1; m_id = 0; m_hold = 0;
    end else if (m_owner >= 0) begin
      if (!r[m_owner] ||
          (TIMEOUT && m_hold >= MAX_HOLD - 1 && (r & ~(4'b0001 << m_owner)) != 4'b0000)) begin
        m_owner = -1;
        m_turn  = 1'b1;
      end else begin
        m_hold++;
      end
    end else begin
      m_turn = 1'b0;
      w = rr_pick(r, m_last);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_id = w; m_hold = 0;
      end
    end
  endtask

  task automatic tick(input logic [3:0] r, input logic rs);
    bus.req = r;
    rst     = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
  endtask

  logic [3:0] prev_grant = 4'b0000;
  bit         mon_en     = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ($countones(bus.grant) > 1 ||
          (bus.grant != 4'b0000 && prev_grant != 4'b0000 && bus.grant != prev_grant)) begin
        errors++;
        $display("FAIL contention grant=%b prev=%b", bus.grant, prev_grant);
      end
      prev_grant = bus.grant;
    end
  end

  task automatic test_reset();
    tick(4'b1111, 1'b1);
    mon_en = 1'b1;
    checks++;
    if (bus.grant !== 4'b0000 || bus.busBusy !== 1'b0 || bus.turnaround !== 1'b0 ||
        bus.ownerId !== 3'd0) begin
      errors++;
      $display("FAIL reset_state grant=%b busy=%b turn=%b id=%0d want 0000/0/0/0",
               bus.grant, bus.busBusy, bus.turnaround, bus.ownerId);
    end
    tick(4'b1111, 1'b0);
    checks++;
    if (bus.grant !== 4'b0001 || bus.ownerId !== 3'd0 || bus.busBusy !== 1'b1) begin
      errors++;
      $display("FAIL reset_priority grant=%b id=%0d busy=%b want 0001/0/1",
               bus.grant, bus.ownerId, bus.busBusy);
    end
    $display("reset: first grant=%b", bus.grant);
  endtask

  task automatic test_rotation();
    for (int o = 0; o < N; o++) begin
      tick(4'b1111 & ~(4'b0001 << o), 1'b0);
      checks++;
      if (bus.grant !== 4'b0000 || bus.turnaround !== 1'b1) begin
        errors++;
        $display("FAIL rotation_turn owner=%0d grant=%b turn=%b want 0000/1",
                 o, bus.grant, bus.turnaround);
      end
      tick(4'b1111, 1'b0);
      checks++;
      if (bus.grant !== (4'b0001 << ((o + 1) % N)) || bus.turnaround !== 1'b0) begin
        errors++;
        $display("FAIL rotation_next from=%0d grant=%b want %b",
                 o, bus.grant, 4'b0001 << ((o + 1) % N));
      end
      $display("rotation: owner %0d -> grant=%b", o, bus.grant);
    end
  endtask

  task automatic test_wrap_sole();
    tick(4'b1110, 1'b0);
    tick(4'b1000, 1'b0);
    checks++;
    if (bus.grant !== 4'b1000 || bus.ownerId !== 3'd3) begin
      errors++;
      $display("FAIL wrap_setup grant=%b id=%0d want 1000/3", bus.grant, bus.ownerId);
    end
    tick(4'b0000, 1'b0);
    tick(4'b1000, 1'b0);
    checks++;
    if (bus.grant !== 4'b1000) begin
      errors++;
      $display("FAIL sole_requester grant=%b want 1000", bus.grant);
    end
    tick(4'b0001, 1'b0);
    checks++;
    if (bus.grant !== 4'b0000 || bus.turnaround !== 1'b1) begin
      errors++;
      $display("FAIL wrap_turn grant=%b turn=%b want 0000/1", bus.grant, bus.turnaround);
    end
    tick(4'b0001, 1'b0);
    checks++;
    if (bus.grant !== 4'b0001 || bus.ownerId !== 3'd0) begin
      errors++;
      $display("FAIL wrap_3_to_0 grant=%b id=%0d want 0001/0", bus.grant, bus.ownerId);
    end
    $display("wrap: sole and 3->0 grant=%b", bus.grant);
  endtask

  task automatic test_mid_reset();
    tick(4'b0000, 1'b0);
    tick(4'b0100, 1'b0);
    checks++;
    if (bus.grant !== 4'b0100) begin
      errors++;
      $display("FAIL midreset_setup grant=%b want 0100", bus.grant);
    end
    tick(4'b0100, 1'b1);
    checks++;
    if (bus.grant !== 4'b0000 || bus.busBusy !== 1'b0 || bus.turnaround !== 1'b0 ||
        bus.ownerId !== 3'd0) begin
      errors++;
      $display("FAIL midreset_clear grant=%b busy=%b turn=%b id=%0d want 0000/0/0/0",
               bus.grant, bus.busBusy, bus.turnaround, bus.ownerId);
    end
    tick(4'b0110, 1'b0);
    checks++;
    if (bus.grant !== 4'b0010 || bus.ownerId !== 3'd1 || bus.turnaround !== 1'b0) begin
      errors++;
      $display("FAIL midreset_first grant=%b id=%0d want 0010/1", bus.grant, bus.ownerId);
    end
    $display("mid-reset: first grant=%b", bus.grant);
  endtask

  task automatic test_timeout();
    tick(4'b0000, 1'b1);
`ifdef ARB_TIMEOUT_EN
    begin
      logic [3:0] pat [11];
      pat = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
              4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
      for (int c = 0; c < 11; c++) begin
        tick(4'b0011, 1'b0);
        checks++;
        if (bus.grant !== pat[c]) begin
          errors++;
          $display("FAIL timeout_preempt cycle=%0d grant=%b want %b", c, bus.grant, pat[c]);
        end
      end
      tick(4'b0000, 1'b1);
      for (int c = 0; c < 22; c++) begin
        tick(4'b0001, 1'b0);
        checks++;
        if (bus.grant !== 4'b0001) begin
          errors++;
          $display("FAIL timeout_saturate cycle=%0d grant=%b want 0001", c, bus.grant);
        end
      end
    end
`else
    for (int c = 0; c < 22; c++) begin
      tick(4'b0011, 1'b0);
      checks++;
      if (bus.grant !== 4'b0001) begin
        errors++;
        $display("FAIL no_timeout_hold cycle=%0d grant=%b want 0001", c, bus.grant);
      end
    end
`endif
    $display("timeout: final grant=%b", bus.grant);
    tick(4'b0000, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       rs;
    logic [3:0] last_seen;
    r = 4'b0000;
    last_seen = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 63) == 0);
      tick(r, rs);
      checks++;
      if (bus.grant !== exp_grant() || bus.busBusy !== (m_owner >= 0) ||
          bus.turnaround !== m_turn) begin
        errors++;
        $display("FAIL random cycle=%0d req=%b grant=%b busy=%b turn=%b want %b/%b/%b",
                 c, r, bus.grant, bus.busBusy, bus.turnaround,
                 exp_grant(), (m_owner >= 0), m_turn);
      end
      if (m_owner >= 0) begin
        checks++;
        if (bus.ownerId !== 3'(m_id)) begin
          errors++;
          $display("FAIL random_owner cycle=%0d id=%0d want %0d", c, bus.ownerId, m_id);
        end
      end
      if (bus.grant != last_seen && bus.grant != 4'b0000)
        $display("random: cycle %0d req=%b grant=%b", c, r, bus.grant);
      last_seen = bus.grant;
    end
  endtask

  initial begin
    bus.req = 4'b0000;
    test_reset();
    test_rotation();
    test_wrap_sole();
    test_mid_reset();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
